// File: rtl/keccak_squeeze_buf.sv
// Keccak squeeze buffer: holds a permuted 1600-bit state and streams its rate lanes one 64-bit lane per transfer, x-fastest.
// Latency: dout_valid_o rises one cycle after the load edge; then up to one lane per cycle.
// Backpressure: dout_o/dout_last_o hold while dout_ready_i=0; state_ready_o is low while streaming. Optional KECCAK_SQUEEZE_ZEROIZE_EN clears the holding register on return to IDLE.
module keccak_squeeze_buf #(
    parameter  int MAX_RATE_LANES = 21,
    localparam int OUT_BUF_SIZE   = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [4:0][4:0][63:0]        state_i,
    input  logic                         state_valid_i,
    output logic                         state_ready_o,
    input  logic [4:0]                   rate_lanes_i,
    input  logic                         abort_i,
    output logic [OUT_BUF_SIZE-1:0]      dout_o,
    output logic                         dout_valid_o,
    input  logic                         dout_ready_i,
    output logic                         dout_last_o,
    output logic                         busy_o
);

    typedef enum logic {IDLE, STREAM} fsm_e;

    localparam logic [4:0] MAX_RATE = 5'(MAX_RATE_LANES);

    fsm_e              state_q, state_d;
    logic [4:0]        cnt_q;
    logic [4:0]        rate_q;
    logic [4:0]        rate_eff;
    logic [24:0][63:0] held_q;
    logic              load;
    logic              xfer;
    logic              last_xfer;

    always_comb begin
        rate_eff = rate_lanes_i;
        if (rate_lanes_i == 5'd0)
            rate_eff = 5'd1;
        else if (rate_lanes_i > MAX_RATE)
            rate_eff = MAX_RATE;
    end

    assign load      = (state_q == IDLE) && state_valid_i && !abort_i;
    assign xfer      = dout_valid_o && dout_ready_i;
    assign last_xfer = xfer && dout_last_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_i)
            state_d = IDLE;
        else begin
            case (state_q)
                IDLE:    if (state_valid_i) state_d = STREAM;
                STREAM:  if (last_xfer)     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        state_ready_o = (state_q == IDLE);
        dout_valid_o  = (state_q == STREAM);
        busy_o        = (state_q != IDLE);
        dout_last_o   = (state_q == STREAM) && (cnt_q == rate_q - 5'd1);
        dout_o        = '0;
        // Packed [plane][sheet] flattens to lane index 5*y+x, so cnt indexes the lane directly.
        if (state_q == STREAM)
            dout_o = held_q[cnt_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            rate_q <= 5'd1;
            held_q <= '0;
        end else if (abort_i || last_xfer) begin
            cnt_q  <= '0;
`ifdef KECCAK_SQUEEZE_ZEROIZE_EN
            held_q <= '0;
`endif
        end else if (load) begin
            cnt_q  <= '0;
            rate_q <= rate_eff;
            held_q <= state_i;
        end else if (xfer) begin
            cnt_q  <= cnt_q + 5'd1;
        end
    end

endmodule

// File: tb/tb_keccak_squeeze_buf.sv
// Self-checking bench for keccak_squeeze_buf: directed table, corner-case sequences and randomized streams vs. a lane-list model.
module tb_keccak_squeeze_buf;

    typedef logic [4:0][4:0][63:0] kstate_t;

    typedef struct {
        int          rate;
        int          n_lanes;
        logic [63:0] last_lane;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    kstate_t     state_i;
    logic        state_valid_i;
    logic        state_ready_o;
    logic [4:0]  rate_lanes_i;
    logic        abort_i;
    logic [63:0] dout_o;
    logic        dout_valid_o;
    logic        dout_ready_i;
    logic        dout_last_o;
    logic        busy_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    keccak_squeeze_buf dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .state_i       (state_i),
        .state_valid_i (state_valid_i),
        .state_ready_o (state_ready_o),
        .rate_lanes_i  (rate_lanes_i),
        .abort_i       (abort_i),
        .dout_o        (dout_o),
        .dout_valid_o  (dout_valid_o),
        .dout_ready_i  (dout_ready_i),
        .dout_last_o   (dout_last_o),
        .busy_o        (busy_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int eff_rate(input int r);
        if (r == 0)  return 1;
        if (r > 21)  return 21;
        return r;
    endfunction

    // Load st, then act as a sink until the DUT drops valid (or n_xfer reaches stop_at).
    // mode: 0 = always ready, 1 = ready toggling 1/0, 2 = random ready.
    task automatic run_stream(input kstate_t st, input int rate, input int mode, input int stop_at,
                              output int n_xfer, output logic [63:0] last_val, output int cycles);
        logic [63:0] expq[$];
        int          eff;
        logic        rdy;
        eff = eff_rate(rate);
        for (int i = 0; i < eff; i++)
            expq.push_back(st[i / 5][i % 5]);
        n_xfer   = 0;
        last_val = '0;
        cycles   = 0;
        state_i       = st;
        rate_lanes_i  = 5'(rate);
        state_valid_i = 1'b1;
        dout_ready_i  = 1'b0;
        check("load_ready", 64'(state_ready_o), 64'd1);
        tick();
        state_valid_i = 1'b0;
        state_i       = '0;
        check("valid_rise", 64'(dout_valid_o), 64'd1);
        while (dout_valid_o) begin
            if (n_xfer == stop_at)
                return;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cycles % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            dout_ready_i = rdy;
            if (n_xfer < eff) begin
                check("lane", dout_o, expq[n_xfer]);
                check("last", 64'(dout_last_o), 64'(n_xfer == eff - 1));
            end else begin
                vectors++;
                miscompares++;
                $display("FAIL extra_lane: got lane %0d (%h), expected only %0d lanes", n_xfer, dout_o, eff);
            end
            cycles++;
            if (rdy) begin
                n_xfer++;
                last_val = dout_o;
            end
            tick();
            if (cycles > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL stream_timeout: got %0d cycles of valid, expected at most 200", cycles);
                break;
            end
        end
        dout_ready_i = 1'b0;
        if (stop_at < 0) begin
            check("busy_after", 64'(busy_o), 64'd0);
            check("dout_zero_idle", dout_o, 64'd0);
        end
    endtask

    initial begin
        kstate_t     pat;
        kstate_t     rst_st;
        vec_t        tbl[9];
        int          n;
        int          c;
        int          r;
        logic [63:0] lv;

        tbl = '{
            '{17, 17, 64'h31}, '{21, 21, 64'h40}, '{0,  1,  64'h00},
            '{31, 21, 64'h40}, '{1,  1,  64'h00}, '{5,  5,  64'h04},
            '{6,  6,  64'h10}, '{22, 21, 64'h40}, '{12, 12, 64'h21}
        };
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                pat[y][x] = 64'((y << 4) | x);

        rst_ni        = 1'b0;
        state_i       = '0;
        state_valid_i = 1'b0;
        rate_lanes_i  = '0;
        abort_i       = 1'b0;
        dout_ready_i  = 1'b0;
        #12;
        check("rst_ready", 64'(state_ready_o), 64'd1);
        check("rst_valid", 64'(dout_valid_o), 64'd0);
        check("rst_last",  64'(dout_last_o), 64'd0);
        check("rst_busy",  64'(busy_o), 64'd0);
        check("rst_dout",  dout_o, 64'd0);
        rst_ni = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_stream(pat, tbl[i].rate, 0, -1, n, lv, c);
            check($sformatf("tbl%0d_count", i), 64'(n), 64'(tbl[i].n_lanes));
            check($sformatf("tbl%0d_final", i), lv, tbl[i].last_lane);
            check($sformatf("tbl%0d_cycles", i), 64'(c), 64'(tbl[i].n_lanes));
        end

        run_stream(pat, 21, 1, -1, n, lv, c);
        check("toggle_count",  64'(n), 64'd21);
        check("toggle_cycles", 64'(c), 64'd41);
        check("toggle_final",  lv, 64'h40);

        // Abort coincident with the transfer of lane 5.
        run_stream(pat, 17, 0, 5, n, lv, c);
        check("abort_pre_lane", dout_o, 64'h10);
        dout_ready_i = 1'b1;
        abort_i      = 1'b1;
        tick();
        abort_i      = 1'b0;
        dout_ready_i = 1'b0;
        check("abort_valid", 64'(dout_valid_o), 64'd0);
        check("abort_busy",  64'(busy_o), 64'd0);
        check("abort_dout",  dout_o, 64'd0);
        tick();
        tick();
        check("abort_stays_idle", 64'(dout_valid_o), 64'd0);
        state_i       = pat;
        state_valid_i = 1'b1;
        abort_i       = 1'b1;
        tick();
        state_valid_i = 1'b0;
        abort_i       = 1'b0;
        check("abort_beats_load", 64'(busy_o), 64'd0);
        run_stream(pat, 9, 0, -1, n, lv, c);
        check("post_abort_count", 64'(n), 64'd9);
        check("post_abort_final", lv, 64'h13);

        // Asynchronous reset mid-stream.
        run_stream(pat, 21, 0, 3, n, lv, c);
        check("pre_rst_lane", dout_o, 64'h03);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_ready", 64'(state_ready_o), 64'd1);
        check("arst_valid", 64'(dout_valid_o), 64'd0);
        check("arst_last",  64'(dout_last_o), 64'd0);
        check("arst_busy",  64'(busy_o), 64'd0);
        check("arst_dout",  dout_o, 64'd0);
        #2 rst_ni = 1'b1;
        dout_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_lane", 64'(dout_valid_o), 64'd0);
        end
        dout_ready_i = 1'b0;

        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                rst_st[y][x] = {$urandom, $urandom};
        run_stream(rst_st, 4, 0, -1, n, lv, c);
        check("reload_count", 64'(n), 64'd4);
`ifdef KECCAK_SQUEEZE_ZEROIZE_EN
        check("zeroized", 64'(dut.held_q == '0), 64'd1);
`endif

        for (int it = 0; it < 30; it++) begin
            kstate_t rs;
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    rs[y][x] = {$urandom, $urandom};
            r = int'($urandom_range(0, 31));
            run_stream(rs, r, 2, -1, n, lv, c);
            check("rand_count", 64'(n), 64'(eff_rate(r)));
            check("rand_final", lv, rs[(eff_rate(r) - 1) / 5][(eff_rate(r) - 1) % 5]);
            if ($urandom_range(0, 2) == 0)
                tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
